// File: rtl/conv_loop_controller_if.sv
// Operand, MAC, partial-sum memory and result handshake bundle
// between the loop controller and its convolution datapath.
interface conv_loop_controller_if #(
  parameter int CNT_W = 16,
  parameter int LOG2_OF_MEM_HEIGHT = 20
);
  logic a_valid;
  logic b_valid;
  logic a_ready;
  logic b_ready;
  logic write_a;
  logic write_b;
  logic mac_valid;
  logic mac_accumulate_internal;
  logic mac_accumulate_with_0;
  logic mem_we;
  logic mem_re;
  logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr;
  logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr;
  logic [CNT_W-1:0] in_x;
  logic [CNT_W-1:0] in_y;
  logic output_valid;
  logic output_ready;
  logic [CNT_W-1:0] output_x;
  logic [CNT_W-1:0] output_y;
  logic [CNT_W-1:0] output_ch;

  modport master (
    input  a_valid, b_valid, output_ready,
    output a_ready, b_ready,
    output write_a, write_b,
    output mac_valid,
    output mac_accumulate_internal,
    output mac_accumulate_with_0,
    output mem_we, mem_re,
    output mem_write_addr, mem_read_addr,
    output in_x, in_y,
    output output_valid,
    output output_x, output_y, output_ch
  );

  modport slave (
    output a_valid, b_valid, output_ready,
    input  a_ready, b_ready,
    input  write_a, write_b,
    input  mac_valid,
    input  mac_accumulate_internal,
    input  mac_accumulate_with_0,
    input  mem_we, mem_re,
    input  mem_write_addr, mem_read_addr,
    input  in_x, in_y,
    input  output_valid,
    input  output_x, output_y, output_ch
  );
endinterface

// File: rtl/conv_loop_controller.sv
// Six-deep convolution loop sequencer: operand fetch, MAC control,
// partial-sum memory strobes and result handshake.
module conv_loop_controller #(
  parameter int CNT_W = 16,
  parameter int LOG2_OF_MEM_HEIGHT = 20
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_out_w,
  input  logic [CNT_W-1:0] cfg_out_h,
  input  logic [CNT_W-1:0] cfg_ch_in,
  input  logic [CNT_W-1:0] cfg_ch_out,
  input  logic [CNT_W-1:0] cfg_kernel,
  input  logic [CNT_W-1:0] cfg_stride,
  output logic             running,
  output logic             done,
  conv_loop_controller_if.master bus
);
  localparam int MW = LOG2_OF_MEM_HEIGHT;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    MAC,
    OUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] out_w;
  logic [CNT_W-1:0] out_h;
  logic [CNT_W-1:0] ch_in;
  logic [CNT_W-1:0] ch_out;
  logic [CNT_W-1:0] kernel;
  logic [CNT_W-1:0] stride;

  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic [CNT_W-1:0] ci;
  logic [CNT_W-1:0] co;
  logic [CNT_W-1:0] kv;
  logic [CNT_W-1:0] kh;

  logic [CNT_W-1:0] ox;
  logic [CNT_W-1:0] oy;
  logic [CNT_W-1:0] och;
  logic [MW-1:0]    waddr;
  logic             we;
  logic             fin;
  logic             done_q;

  logic latch;
  logic step;
  logic fin_hs;
  logic cfg_zero;
  logic kh_l, kv_l, co_l, ci_l, y_l, x_l;
  logic c_kv, c_co, c_ci, c_y, c_x;
  logic blk_last;
  logic all_last;
  logic k_first;

  function automatic logic [CNT_W-1:0] bump(
    input logic [CNT_W-1:0] v,
    input logic             l
  );
    return l ? '0 : v + ONE;
  endfunction

  assign cfg_zero = (cfg_out_w == '0)
                 || (cfg_out_h == '0)
                 || (cfg_ch_in == '0)
                 || (cfg_ch_out == '0)
                 || (cfg_kernel == '0);

  assign kh_l = (kh == kernel - ONE);
  assign kv_l = (kv == kernel - ONE);
  assign co_l = (co == ch_out - ONE);
  assign ci_l = (ci == ch_in - ONE);
  assign y_l  = (y == out_h - ONE);
  assign x_l  = (x == out_w - ONE);

  // Carry chain, innermost k_h outward to x.
  assign c_kv = kh_l;
  assign c_co = c_kv & kv_l;
  assign c_ci = c_co & co_l;
  assign c_y  = c_ci & ci_l;
  assign c_x  = c_y & y_l;

  assign blk_last = c_co & ci_l;
  assign all_last = c_x & x_l;
  assign k_first  = (kv == '0) && (kh == '0);

  assign running = (state != IDLE);
  assign done    = done_q;

  assign bus.in_x = x * stride + kh;
  assign bus.in_y = y * stride + kv;
  assign bus.mem_read_addr  = MW'(co);
  assign bus.mem_write_addr = waddr;
  assign bus.mem_we         = we;
  assign bus.output_x       = ox;
  assign bus.output_y       = oy;
  assign bus.output_ch      = och;

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    step      = 1'b0;
    fin_hs    = 1'b0;
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    bus.write_a = 1'b0;
    bus.write_b = 1'b0;
    bus.mac_valid = 1'b0;
    bus.mac_accumulate_internal = 1'b0;
    bus.mac_accumulate_with_0   = 1'b0;
    bus.mem_re = 1'b0;
    bus.output_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          latch = 1'b1;
          if (!cfg_zero) state_nxt = FETCH;
        end
      end
      FETCH: begin
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        bus.write_a = bus.a_valid;
        bus.write_b = bus.b_valid;
        if (bus.a_valid && bus.b_valid)
          state_nxt = MAC;
      end
      MAC: begin
        step = 1'b1;
        bus.mac_valid = 1'b1;
        bus.mac_accumulate_internal = !k_first;
        bus.mac_accumulate_with_0 =
          k_first && (ci == '0);
        bus.mem_re = k_first && (ci != '0);
        state_nxt = blk_last ? OUT : FETCH;
      end
      OUT: begin
        bus.output_valid = 1'b1;
        if (bus.output_ready) begin
          fin_hs    = fin;
          state_nxt = fin ? IDLE : FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      out_w  <= '0;
      out_h  <= '0;
      ch_in  <= '0;
      ch_out <= '0;
      kernel <= '0;
      stride <= '0;
      x  <= '0;
      y  <= '0;
      ci <= '0;
      co <= '0;
      kv <= '0;
      kh <= '0;
      ox  <= '0;
      oy  <= '0;
      och <= '0;
      waddr  <= '0;
      we     <= 1'b0;
      fin    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (latch & cfg_zero) | fin_hs;
      // Write-back only for blocks whose ch_in sum is still partial.
      we <= step & c_co & !ci_l;
      if (latch) begin
        out_w  <= cfg_out_w;
        out_h  <= cfg_out_h;
        ch_in  <= cfg_ch_in;
        ch_out <= cfg_ch_out;
        kernel <= cfg_kernel;
        stride <= cfg_stride;
        x  <= '0;
        y  <= '0;
        ci <= '0;
        co <= '0;
        kv <= '0;
        kh <= '0;
      end
      if (step) begin
        waddr <= MW'(co);
        kh <= bump(kh, kh_l);
        if (c_kv) kv <= bump(kv, kv_l);
        if (c_co) co <= bump(co, co_l);
        if (c_ci) ci <= bump(ci, ci_l);
        if (c_y)  y  <= bump(y, y_l);
        if (c_x)  x  <= bump(x, x_l);
        if (blk_last) begin
          ox  <= x;
          oy  <= y;
          och <= co;
          fin <= all_last;
        end
      end
    end
  end
endmodule
